// File: rtl/inst_prefetch_pkg.sv
// Shared constants for the instruction prefetch front end.
// Chip-enable encodings, reset polarity, default widths, FSM states.
package inst_prefetch_pkg;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic RST_ENABLE   = 1'b1;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam int INST_ADDR_W    = 32;
    localparam int INST_DATA_W    = 32;
    localparam int PREFETCH_DEPTH = 4;

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/inst_prefetch_if.sv
// Valid/ready bundle carrying {pc, inst} from prefetch to IF/ID.
// master drives valid/pc/inst, slave drives ready.
interface inst_prefetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);

    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;

    modport master (
        output valid,
        output pc,
        output inst,
        input  ready
    );

    modport slave (
        input  valid,
        input  pc,
        input  inst,
        output ready
    );

endinterface

// File: rtl/inst_prefetch_fifo.sv
// Synchronous DEPTH-entry FIFO for fetched {pc, inst} pairs.
// flush empties it in one cycle; head data is read combinationally.
module inst_prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    assign rdata = mem[head];

    // Storage write at the tail; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= wdata;
        end
    end

    // Pointers and occupancy; flush and reset discard everything.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction fetch front end: fetch PC, ROM drive, prefetch buffer.
// Decouples ROM access from IF/ID stalls; redirects flush the buffer.
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int INST_W = INST_DATA_W,
    parameter int DEPTH  = PREFETCH_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    inst_prefetch_if.master   out
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int W  = ADDR_W + INST_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [0:0]        state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CW-1:0]     count;
    logic [W-1:0]      rdata;
    logic              push;
    logic              pop;
    logic              valid;
    logic              unused_low_bits;

    assign unused_low_bits = ^redirect_pc[1:0];

    assign push  = (state == ST_RUN) && !redirect && (count < FULL);
    assign valid = (count != '0) && !redirect;
    assign pop   = valid && out.ready;

    assign rom_ce   = push ? CHIP_ENABLE : CHIP_DISABLE;
    assign rom_addr = push ? fetch_pc : ADDR_W'(ZERO_WORD);

    assign out.valid = valid;
    assign out.pc    = valid ? rdata[W-1:INST_W] : '0;
    assign out.inst  = valid ? rdata[INST_W-1:0] : '0;

    // BOOT holds through reset plus one cycle, then RUN until reset.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state <= ST_BOOT;
        end else begin
            state <= ST_RUN;
        end
    end

    // Fetch PC: reset vector, word-aligned redirect, or next word.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (push) begin
            fetch_pc <= fetch_pc + ADDR_W'(4);
        end
    end

    inst_prefetch_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({fetch_pc, rom_inst}),
        .rdata (rdata),
        .count (count)
    );

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed and randomized checks for inst_prefetch.
// ROM model returns word(addr) = (addr >> 2) ^ 32'hC0DE_0000.
module tb_inst_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect;
    logic [31:0] redirect_pc;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    inst_prefetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

    inst_prefetch #(
        .ADDR_W   (32),
        .INST_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_ce      (rom_ce),
        .rom_addr    (rom_addr),
        .rom_inst    (rom_inst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out         (bus)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a >> 2) ^ 32'hC0DE_0000;
    endfunction

    assign rom_inst = word(rom_addr);

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        bus.ready = 1'b1;
        cyc();
        #1;
        tests++; if (rom_ce !== 1'b0) begin fails++; $display("FAIL reset_ce got %b want 0", rom_ce); end
        tests++; if (rom_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want 0", rom_addr); end
        tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.valid); end
        tests++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want 0", bus.pc); end
        tests++; if (bus.inst !== 32'h0) begin fails++; $display("FAIL reset_inst got %h want 0", bus.inst); end
        cyc();
        rst = 1'b0;
        #1;
        tests++; if (rom_ce !== 1'b0 || bus.valid !== 1'b0) begin fails++; $display("FAIL boot_idle got ce=%b v=%b want 0 0", rom_ce, bus.valid); end
        cyc();
        #1;
        tests++; if (rom_ce !== 1'b1 || rom_addr !== 32'h0) begin fails++; $display("FAIL first_fetch got ce=%b a=%h want 1 0", rom_ce, rom_addr); end
        tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL first_fetch_valid got %b want 0", bus.valid); end
        cyc();
        #1;
        tests++; if (bus.valid !== 1'b1 || bus.pc !== 32'h0 || bus.inst !== word(32'h0)) begin fails++; $display("FAIL first_out got v=%b pc=%h i=%h want 1 0 %h", bus.valid, bus.pc, bus.inst, word(32'h0)); end
        tests++; if (rom_addr !== 32'h4) begin fails++; $display("FAIL second_fetch got %h want 4", rom_addr); end
        cyc();
        exp_pc = 32'h4;
    endtask

    task automatic test_stream;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++; if (bus.valid !== 1'b1 || bus.pc !== exp_pc || bus.inst !== word(exp_pc)) begin fails++; $display("FAIL stream got v=%b pc=%h i=%h want 1 %h %h", bus.valid, bus.pc, bus.inst, exp_pc, word(exp_pc)); end
            tests++; if (dut.count !== 3'd1 || rom_addr !== exp_pc + 32'd4) begin fails++; $display("FAIL stream_cnt got c=%0d a=%h want 1 %h", dut.count, rom_addr, exp_pc + 32'd4); end
            exp_pc = exp_pc + 32'd4;
            cyc();
        end
    endtask

    task automatic test_stall;
        bus.ready = 1'b0;
        #1;
        tests++; if (bus.valid !== 1'b1 || bus.pc !== exp_pc) begin fails++; $display("FAIL stall_head got v=%b pc=%h want 1 %h", bus.valid, bus.pc, exp_pc); end
        for (int i = 0; i < 10; i++) cyc();
        bus.ready = 1'b1;
        #1;
        tests++; if (dut.count !== 3'd4) begin fails++; $display("FAIL stall_full got %0d want 4", dut.count); end
        tests++; if (rom_ce !== 1'b0 || rom_addr !== 32'h0) begin fails++; $display("FAIL stall_ce got ce=%b a=%h want 0 0", rom_ce, rom_addr); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (bus.valid !== 1'b1 || bus.pc !== exp_pc || bus.inst !== word(exp_pc)) begin fails++; $display("FAIL release got v=%b pc=%h i=%h want 1 %h %h", bus.valid, bus.pc, bus.inst, exp_pc, word(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
            cyc();
            #1;
        end
    endtask

    task automatic test_redirect;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0102;
        #1;
        tests++; if (dut.count !== 3'd3) begin fails++; $display("FAIL redir_cnt got %0d want 3", dut.count); end
        tests++; if (bus.valid !== 1'b0 || rom_ce !== 1'b0 || rom_addr !== 32'h0) begin fails++; $display("FAIL redir_cycle got v=%b ce=%b a=%h want 0 0 0", bus.valid, rom_ce, rom_addr); end
        cyc();
        redirect = 1'b0;
        #1;
        tests++; if (rom_ce !== 1'b1 || rom_addr !== 32'h100 || bus.valid !== 1'b0) begin fails++; $display("FAIL redir_fetch got ce=%b a=%h v=%b want 1 100 0", rom_ce, rom_addr, bus.valid); end
        cyc();
        #1;
        tests++; if (bus.valid !== 1'b1 || bus.pc !== 32'h100 || bus.inst !== word(32'h100)) begin fails++; $display("FAIL redir_out got v=%b pc=%h i=%h want 1 100 %h", bus.valid, bus.pc, bus.inst, word(32'h100)); end
        cyc();
        #1;
        tests++; if (bus.valid !== 1'b1 || bus.pc !== 32'h104) begin fails++; $display("FAIL redir_next got v=%b pc=%h want 1 104", bus.valid, bus.pc); end
        cyc();
    endtask

    task automatic test_wrap;
        logic [31:0] seq [3];
        seq[0] = 32'hFFFF_FFFC;
        seq[1] = 32'h0000_0000;
        seq[2] = 32'h0000_0004;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        #1;
        tests++; if (rom_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_fetch got %h want fffffffc", rom_addr); end
        cyc();
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (bus.valid !== 1'b1 || bus.pc !== seq[i] || bus.inst !== word(seq[i])) begin fails++; $display("FAIL wrap got v=%b pc=%h want 1 %h", bus.valid, bus.pc, seq[i]); end
            cyc();
        end
    endtask

    task automatic test_rst_full;
        bus.ready = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        #1;
        tests++; if (dut.count !== 3'd4) begin fails++; $display("FAIL rf_full got %0d want 4", dut.count); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        tests++; if (bus.valid !== 1'b0 || bus.pc !== 32'h0 || bus.inst !== 32'h0) begin fails++; $display("FAIL rf_out got v=%b pc=%h i=%h want 0 0 0", bus.valid, bus.pc, bus.inst); end
        tests++; if (rom_ce !== 1'b0 || dut.count !== 3'd0) begin fails++; $display("FAIL rf_ce got ce=%b c=%0d want 0 0", rom_ce, dut.count); end
        cyc();
        #1;
        tests++; if (rom_ce !== 1'b1 || rom_addr !== 32'h0) begin fails++; $display("FAIL rf_refetch got ce=%b a=%h want 1 0", rom_ce, rom_addr); end
        bus.ready = 1'b1;
        cyc();
        #1;
        tests++; if (bus.valid !== 1'b1 || bus.pc !== 32'h0 || bus.inst !== word(32'h0)) begin fails++; $display("FAIL rf_first got v=%b pc=%h want 1 0", bus.valid, bus.pc); end
        cyc();
    endtask

    task automatic test_random;
        int delivered = 0;
        for (int i = 0; i < 10000; i++) begin
            redirect = (i == 0) || ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            bus.ready = ($urandom_range(0, 3) != 0);
            #1;
            if (redirect) begin
                tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL rnd_redir_valid got %b want 0 at %0d", bus.valid, i); end
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else if (bus.valid === 1'b1) begin
                if (bus.ready) begin
                    tests++; if (bus.pc !== exp_pc || bus.inst !== word(exp_pc)) begin fails++; $display("FAIL rnd_out got pc=%h i=%h want %h %h at %0d", bus.pc, bus.inst, exp_pc, word(exp_pc), i); end
                    exp_pc = exp_pc + 32'd4;
                    delivered++;
                end
            end else begin
                tests++; if (bus.pc !== 32'h0 || bus.inst !== 32'h0) begin fails++; $display("FAIL rnd_idle got pc=%h i=%h want 0 0 at %0d", bus.pc, bus.inst, i); end
            end
            tests++; if (dut.count > 3'd4) begin fails++; $display("FAIL rnd_cnt got %0d want <=4 at %0d", dut.count, i); end
            cyc();
        end
        redirect = 1'b0;
        tests++; if (delivered < 2000) begin fails++; $display("FAIL rnd_progress got %0d want >=2000", delivered); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_rst_full();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
